// File: rtl/cs_adder_pkg.sv
// Shared sizing helpers for the pipelined carry-propagate final adder.
// Slice k covers result bits [slice_hi:slice_lo]; the last slice may be narrower.
package cs_adder_pkg;

  function automatic int num_stages(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int slice_lo(input int k, input int chunk);
    return k * chunk;
  endfunction

  function automatic int slice_hi(input int k, input int width, input int chunk);
    return (((k + 1) * chunk) > width) ? (width - 1) : (((k + 1) * chunk) - 1);
  endfunction

endpackage

// File: rtl/cs_adder_slice.sv
// One elastic pipeline stage of the final adder: adds slice K of the carried
// operands plus the incoming carry and forwards the remaining operand bits.
module cs_adder_slice
  import cs_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_in,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             ready_in,
  output logic             ready_out,
  output logic             v_out,
  output logic             c_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int LO = slice_lo(K, CHUNK);
  localparam int HI = slice_hi(K, WIDTH, CHUNK);
  localparam int SW = HI - LO + 1;

  logic             v_q, v_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [SW:0]      sum_s;
  logic             load_s;

  assign ready_out = !v_q || ready_in;

  // Slice addition and load/hold selection; data only moves on a real transfer.
  always_comb begin
    sum_s  = {1'b0, a_in[HI:LO]} + {1'b0, b_in[HI:LO]} + {{SW{1'b0}}, c_in};
    load_s = ready_out && v_in;
    v_d    = v_q;
    c_d    = c_q;
    a_d    = a_q;
    b_d    = b_q;
    lo_d   = lo_q;
    if (ready_out) begin
      v_d = v_in;
    end else begin
      v_d = v_q;
    end
    if (load_s) begin
      a_d         = a_in;
      b_d         = b_in;
      lo_d        = lo_in;
      lo_d[HI:LO] = sum_s[SW-1:0];
      c_d         = sum_s[SW];
    end else begin
      lo_d = lo_q;
    end
  end

  // Stage registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q  <= 1'b0;
      c_q  <= 1'b0;
      a_q  <= {WIDTH{1'b0}};
      b_q  <= {WIDTH{1'b0}};
      lo_q <= {WIDTH{1'b0}};
    end else begin
      v_q  <= v_d;
      c_q  <= c_d;
      a_q  <= a_d;
      b_q  <= b_d;
      lo_q <= lo_d;
    end
  end

  assign v_out  = v_q;
  assign c_out  = c_q;
  assign a_out  = a_q;
  assign b_out  = b_q;
  assign lo_out = lo_q;

endmodule

// File: rtl/cs_final_adder.sv
// Pipelined final adder for the compressor tree: CHUNK bits per stage, carry
// registered between stages, valid/ready elastic chain without skid buffer.
module cs_final_adder
  import cs_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy
);

  localparam int STAGES = num_stages(WIDTH, CHUNK);

  logic             v_s   [0:STAGES];
  logic             c_s   [0:STAGES];
  logic             rdy_s [0:STAGES];
  logic [WIDTH-1:0] a_s   [0:STAGES];
  logic [WIDTH-1:0] b_s   [0:STAGES];
  logic [WIDTH-1:0] lo_s  [0:STAGES];
  logic             busy_s;

  assign v_s[0]       = in_valid;
  assign c_s[0]       = 1'b0;
  assign a_s[0]       = in_a;
  assign b_s[0]       = in_b;
  assign lo_s[0]      = {WIDTH{1'b0}};
  assign rdy_s[STAGES] = out_ready;
  assign in_ready     = rdy_s[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cs_adder_slice #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .K     (k)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .v_in      (v_s[k]),
      .c_in      (c_s[k]),
      .a_in      (a_s[k]),
      .b_in      (b_s[k]),
      .lo_in     (lo_s[k]),
      .ready_in  (rdy_s[k+1]),
      .ready_out (rdy_s[k]),
      .v_out     (v_s[k+1]),
      .c_out     (c_s[k+1]),
      .a_out     (a_s[k+1]),
      .b_out     (b_s[k+1]),
      .lo_out    (lo_s[k+1])
    );
  end

  // Any occupied stage means work is in flight.
  always_comb begin
    busy_s = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      busy_s = busy_s | v_s[k];
    end
  end

  assign busy      = busy_s;
  assign out_valid = v_s[STAGES];
  assign out_sum   = {c_s[STAGES], lo_s[STAGES]};

endmodule

// File: tb/tb_cs_final_adder.sv
// Self-checking bench: queue-based reference (sum = a + b, FIFO order, capacity
// STAGES) plus directed literal checks, on a 32/8 and a 20/8 instance.
module tb_cs_final_adder;

  localparam int W   = 32;
  localparam int W2  = 20;
  localparam int C   = 8;
  localparam int ST  = 4;
  localparam int ST2 = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  in_a, in_b;
  logic [W:0]    out_sum;
  logic          in_valid_n, in_ready_n, out_valid_n, out_ready_n, busy_n;
  logic [W2-1:0] in_a_n, in_b_n;
  logic [W2:0]   out_sum_n;

  int          nvec = 0;
  int          nerr = 0;
  logic [W:0]  sb_q[$];
  logic [W:0]  got_q[$];
  bit          prev_stall = 1'b0;
  logic [W:0]  prev_sum;

  always #5 clk = ~clk;

  cs_final_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .busy(busy)
  );

  cs_final_adder #(.WIDTH(W2), .CHUNK(C)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .in_a(in_a_n), .in_b(in_b_n), .out_valid(out_valid_n), .out_ready(out_ready_n),
    .out_sum(out_sum_n), .busy(busy_n)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: in-flight pairs as a queue of expected sums.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", out_sum, prev_sum);
      end
      check("busy", busy, sb_q.size() != 0);
      check("in_ready", in_ready, !(sb_q.size() == ST && !out_ready));
      if (out_valid && out_ready) begin
        check("emit_has_entry", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) check("sum", out_sum, sb_q.pop_front());
        got_q.push_back(out_sum);
      end
      if (in_valid && in_ready) sb_q.push_back({1'b0, in_a} + {1'b0, in_b});
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
    end
  end

  task automatic run_narrow(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic [W2:0] exp);
    int lat;
    tick();
    in_valid_n = 1'b1;
    in_a_n = a;
    in_b_n = b;
    @(negedge clk);
    check("n_in_ready", in_ready_n, 1);
    tick();
    in_valid_n = 1'b0;
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
    end while (!out_valid_n && lat < 20);
    check("n_latency", lat, ST2);
    check("n_sum", out_sum_n, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, acc, nxt, cyc, cnt, base;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    in_valid_n = 1'b0; in_a_n = '0; in_b_n = '0; out_ready_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // All-ones plus one: carry ripples through every slice.
    tick();
    out_ready = 1'b1; in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001;
    @(negedge clk);
    check("t1_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    check("t1_latency", lat, ST);
    check("t1_sum", out_sum, 33'h1_0000_0000);
    repeat (2) @(negedge clk);
    check("t1_drain_busy", busy, 0);

    // Back-to-back stream at full rate.
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      check("b2b_in_ready", in_ready, 1);
      if (i >= ST) check("b2b_out_valid", out_valid, 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();

    // Backpressure: only STAGES pairs fit.
    out_ready = 1'b0;
    got_q.delete();
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_a = i; in_b = 16 * i;
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", acc, 4);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_sum", out_sum, 33'h11);
    tick();
    out_ready = 1'b1;
    nxt = 5; cyc = 0;
    while (got_q.size() < 6 && cyc < 50) begin
      in_valid = (nxt <= 6); in_a = nxt; in_b = 16 * nxt;
      @(negedge clk);
      if (in_valid && in_ready) nxt++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("bp_count", got_q.size(), 6);
    for (int j = 0; j < 6 && j < got_q.size(); j++) check("bp_order", got_q[j], 33'h11 * (j + 1));

    // Narrow last slice on the 20-bit instance.
    run_narrow(20'hFFFFF, 20'hFFFFF, 21'h1FFFFE);
    run_narrow(20'h000FF, 20'h00001, 21'h00100);
    run_narrow(20'h0FFFF, 20'h00001, 21'h10000);
    run_narrow(20'hF0000, 20'h10000, 21'h100000);

    // Reset with three pairs in flight.
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_out_sum", out_sum, 0);
    check("mrst_in_ready", in_ready, 1);
    base = got_q.size();
    tick();
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd7;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    check("mrst_latency", lat, ST);
    check("mrst_sum", out_sum, 33'd12);
    repeat (5) tick();
    check("mrst_emits", got_q.size(), base + 1);

    // Random valid/ready toggling on both sides.
    cnt = 0; cyc = 0;
    in_valid = 1'b0;
    while (cnt < 1000 && cyc < 20000) begin
      tick();
      if (!in_valid) begin
        in_valid = $urandom_range(0, 1);
        in_a = $urandom; in_b = $urandom;
      end
      out_ready = $urandom_range(0, 1);
      @(negedge clk);
      if (in_valid && in_ready) begin
        cnt++;
        tick();
        in_valid = $urandom_range(0, 1);
        in_a = $urandom; in_b = $urandom;
        out_ready = $urandom_range(0, 1);
        @(negedge clk);
        if (in_valid && in_ready) begin
          cnt++;
          in_valid = 1'b0;
        end
      end
      cyc++;
    end
    check("rand_pairs", cnt >= 1000, 1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    check("rand_drained", sb_q.size(), 0);
    check("rand_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
